// File: rtl/lfsr_prng_pkg.sv
// Shared definitions for the LFSR pseudo-random word source.
// Contents: step-mode constants, the delivery FSM state type and a
// table of maximal-length tap masks for state widths 4..32.
package lfsr_prng_pkg;

  localparam int MODE_FIBONACCI = 0;
  localparam int MODE_GALOIS    = 1;

  // HOLD: word on rand_o is offered to the consumer.
  // FILL: extra decimation shifts are being applied; no word offered.
  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_FILL = 1'b1
  } fsm_t;

  // Maximal-length masks for the left-shifting Fibonacci form used here:
  // bit i set means state[i] feeds the XOR that enters state[0], i.e. the
  // feedback polynomial has the term x^(i+1). Unsupported widths return 0.
  function automatic logic [31:0] max_len_taps(input int width);
    logic [31:0] mask;
    case (width)
      4:  mask = 32'h0000_000C;
      5:  mask = 32'h0000_0014;
      6:  mask = 32'h0000_0030;
      7:  mask = 32'h0000_0060;
      8:  mask = 32'h0000_00B8;
      9:  mask = 32'h0000_0110;
      10: mask = 32'h0000_0240;
      11: mask = 32'h0000_0500;
      12: mask = 32'h0000_0829;
      13: mask = 32'h0000_100D;
      14: mask = 32'h0000_2015;
      15: mask = 32'h0000_6000;
      16: mask = 32'h0000_D008;
      17: mask = 32'h0001_2000;
      18: mask = 32'h0002_0400;
      19: mask = 32'h0004_0023;
      20: mask = 32'h0009_0000;
      21: mask = 32'h0014_0000;
      22: mask = 32'h0030_0000;
      23: mask = 32'h0042_0000;
      24: mask = 32'h00E1_0000;
      25: mask = 32'h0120_0000;
      26: mask = 32'h0200_0023;
      27: mask = 32'h0400_0013;
      28: mask = 32'h0900_0000;
      29: mask = 32'h1400_0000;
      30: mask = 32'h2000_0029;
      31: mask = 32'h4800_0000;
      32: mask = 32'h8020_0003;
      default: mask = 32'h0000_0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lfsr_prng_step.sv
// Combinational LFSR next-state function (one shift).
// Ports: state (current value), taps (participation mask), next_state.
// GALOIS selects internal-XOR form; otherwise Fibonacci external-XOR form.
module lfsr_step
  import lfsr_prng_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int GALOIS = MODE_FIBONACCI
) (
  input  logic [WIDTH-1:0] state,
  input  logic [WIDTH-1:0] taps,
  output logic [WIDTH-1:0] next_state
);

  generate
    if (GALOIS == MODE_GALOIS) begin : g_galois
      // Outgoing MSB conditionally XORs the tap mask into the shifted word.
      assign next_state = {state[WIDTH-2:0], 1'b0} ^ (state[WIDTH-1] ? taps : '0);
    end else begin : g_fibonacci
      // Parity of the tapped bits enters at the LSB.
      assign next_state = {state[WIDTH-2:0], ^(state & taps)};
    end
  endgenerate

endmodule

// File: rtl/lfsr_prng.sv
// LFSR pseudo-random word source with run-time taps/seed, decimation and
// valid/ready delivery. Ports: clk_i/rst_i, en_i, seed/taps load strobes,
// rand_o/rand_valid_o/rand_ready_i handshake, lockup_o recovery pulse.
module lfsr_prng
  import lfsr_prng_pkg::*;
#(
  parameter int              WIDTH        = 8,
  parameter int              OUT_W        = 8,
  parameter logic [WIDTH-1:0] DEFAULT_TAPS = WIDTH'(max_len_taps(WIDTH)),
  parameter logic [WIDTH-1:0] DEFAULT_SEED = '1,
  parameter int              GALOIS       = MODE_FIBONACCI,
  parameter int              STEPS        = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             seed_we_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             taps_we_i,
  input  logic [WIDTH-1:0] taps_i,
  output logic [OUT_W-1:0] rand_o,
  output logic             rand_valid_o,
  input  logic             rand_ready_i,
  output logic             lockup_o
);

  // Shifts still owed after the first one taken on the accepting edge.
  localparam logic [7:0] FILL_CNT = 8'(STEPS - 1);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] taps;
  logic [WIDTH-1:0] next_state;
  logic [7:0]       cnt;
  fsm_t             fsm;

  lfsr_step #(
    .WIDTH  (WIDTH),
    .GALOIS (GALOIS)
  ) u_step (
    .state      (state),
    .taps       (taps),
    .next_state (next_state)
  );

  assign rand_o       = state[WIDTH-1 -: OUT_W];
  // Valid follows en_i combinationally so a disabled source never offers a word.
  assign rand_valid_o = en_i & (fsm == ST_HOLD);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= DEFAULT_SEED;
      taps     <= DEFAULT_TAPS;
      fsm      <= ST_HOLD;
      cnt      <= '0;
      lockup_o <= 1'b0;
    end else begin
      lockup_o <= 1'b0;

      // New taps take effect from the next edge; any step on this edge
      // already sees the old register value through next_state.
      if (taps_we_i) begin
        taps <= taps_i;
      end

      if (seed_we_i) begin
        // A zero seed would lock the register, so substitute the default.
        state <= (seed_i == '0) ? DEFAULT_SEED : seed_i;
        fsm   <= ST_HOLD;
        cnt   <= '0;
      end else if (state == '0) begin
        // Zero is a fixed point of both step forms; escape it regardless of en_i.
        state    <= DEFAULT_SEED;
        fsm      <= ST_HOLD;
        cnt      <= '0;
        lockup_o <= 1'b1;
      end else if (en_i) begin
        case (fsm)
          ST_HOLD: begin
            if (rand_ready_i) begin
              state <= next_state;
              if (STEPS > 1) begin
                cnt <= FILL_CNT;
                fsm <= ST_FILL;
              end
            end
          end
          ST_FILL: begin
            state <= next_state;
            cnt   <= cnt - 8'd1;
            // Leave FILL as the final owed shift lands.
            if (cnt <= 8'd1) begin
              fsm <= ST_HOLD;
            end
          end
          default: begin
            fsm <= ST_HOLD;
            cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_prng.sv
// Directed bench for lfsr_prng: one instance with STEPS=1, one with STEPS=3,
// driven by shared inputs. Each task checks its own scenario inline.
module tb_lfsr_prng;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       seed_we;
  logic [7:0] seed;
  logic       taps_we;
  logic [7:0] taps;
  logic       ready;

  logic [7:0] r1, r3;
  logic       v1, v3, l1, l3;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  lfsr_prng #(.STEPS(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .seed_we_i(seed_we), .seed_i(seed),
    .taps_we_i(taps_we), .taps_i(taps), .rand_o(r1), .rand_valid_o(v1),
    .rand_ready_i(ready), .lockup_o(l1)
  );

  lfsr_prng #(.STEPS(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .seed_we_i(seed_we), .seed_i(seed),
    .taps_we_i(taps_we), .taps_i(taps), .rand_o(r3), .rand_valid_o(v3),
    .rand_ready_i(ready), .lockup_o(l3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; ready = 1'b0;
    seed_we = 1'b0; seed = 8'h00; taps_we = 1'b0; taps = 8'h00;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; ready = 1'b0;
    seed_we = 1'b0; seed = 8'h00; taps_we = 1'b0; taps = 8'h00;
    #2;
    n_checks++; if (r1 !== 8'hFF) $display("FAIL reset_rand: got %h want ff", r1); else n_pass++;
    n_checks++; if (v1 !== 1'b0) $display("FAIL reset_valid_en0: got %b want 0", v1); else n_pass++;
    n_checks++; if (l1 !== 1'b0) $display("FAIL reset_lockup: got %b want 0", l1); else n_pass++;
    en = 1'b1;
    #1;
    n_checks++; if (v3 !== 1'b1) $display("FAIL reset_valid_en1: got %b want 1", v3); else n_pass++;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_default_sequence();
    logic [7:0] exp [6];
    exp = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE1};
    do_reset();
    en = 1'b1; ready = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (r1 !== exp[i] || v1 !== 1'b1)
        $display("FAIL default_seq[%0d]: got %h/v%b want %h/v1", i, r1, v1, exp[i]);
      else n_pass++;
      if (i < 5) tick();
    end
  endtask

  task automatic test_period();
    int  fires = 0;
    bit  saw_lock = 0;
    bit  saw_zero = 0;
    do_reset();
    en = 1'b1; ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      fires++;
      if (l1) saw_lock = 1;
      if (r1 == 8'h00) saw_zero = 1;
      if (r1 == 8'hFF) break;
    end
    n_checks++; if (fires != 255) $display("FAIL period: got %0d want 255", fires); else n_pass++;
    n_checks++; if (saw_lock || saw_zero)
      $display("FAIL period_clean: got lock=%b zero=%b want 0/0", saw_lock, saw_zero); else n_pass++;
  endtask

  task automatic test_decimation();
    do_reset();
    en = 1'b1; ready = 1'b1;
    tick();
    ready = 1'b0;
    n_checks++; if (v3 !== 1'b0) $display("FAIL dec_fill1_valid: got %b want 0", v3); else n_pass++;
    tick();
    n_checks++; if (v3 !== 1'b0) $display("FAIL dec_fill2_valid: got %b want 0", v3); else n_pass++;
    tick();
    n_checks++; if (r3 !== 8'hF8 || v3 !== 1'b1)
      $display("FAIL dec_word: got %h/v%b want f8/v1", r3, v3); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (r3 !== 8'hF8 || v3 !== 1'b1)
        $display("FAIL dec_hold[%0d]: got %h/v%b want f8/v1", i, r3, v3); else n_pass++;
    end
  endtask

  task automatic test_seed();
    do_reset();
    en = 1'b1; ready = 1'b1;
    tick();
    tick();
    n_checks++; if (r1 !== 8'hFC) $display("FAIL seed_pre: got %h want fc", r1); else n_pass++;
    seed_we = 1'b1; seed = 8'h00;
    tick();
    seed_we = 1'b0;
    n_checks++; if (r1 !== 8'hFF || v1 !== 1'b1)
      $display("FAIL seed_zero: got %h/v%b want ff/v1", r1, v1); else n_pass++;
    tick();
    n_checks++; if (r3 !== 8'hFE || v3 !== 1'b0)
      $display("FAIL seed_midfill_pre: got %h/v%b want fe/v0", r3, v3); else n_pass++;
    seed_we = 1'b1; seed = 8'h5A;
    tick();
    seed_we = 1'b0;
    n_checks++; if (r3 !== 8'h5A || v3 !== 1'b1)
      $display("FAIL seed_midfill: got %h/v%b want 5a/v1", r3, v3); else n_pass++;
    tick();
    n_checks++; if (r3 !== 8'hB4 || v3 !== 1'b0)
      $display("FAIL seed_refill1: got %h/v%b want b4/v0", r3, v3); else n_pass++;
    tick();
    n_checks++; if (r3 !== 8'h69 || v3 !== 1'b0)
      $display("FAIL seed_refill2: got %h/v%b want 69/v0", r3, v3); else n_pass++;
    tick();
    n_checks++; if (r3 !== 8'hD2 || v3 !== 1'b1)
      $display("FAIL seed_refill_word: got %h/v%b want d2/v1", r3, v3); else n_pass++;
    en = 1'b0; seed_we = 1'b1; seed = 8'h3C;
    tick();
    seed_we = 1'b0;
    n_checks++; if (r1 !== 8'h3C || v1 !== 1'b0)
      $display("FAIL seed_en0: got %h/v%b want 3c/v0", r1, v1); else n_pass++;
  endtask

  task automatic test_lockup();
    logic [7:0] exp [8];
    exp = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
    do_reset();
    taps_we = 1'b1; taps = 8'h00;
    tick();
    taps_we = 1'b0;
    en = 1'b1; ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++; if (r1 !== exp[i] || l1 !== 1'b0)
        $display("FAIL lock_shift[%0d]: got %h/l%b want %h/l0", i, r1, l1, exp[i]); else n_pass++;
    end
    tick();
    n_checks++; if (l1 !== 1'b1 || r1 !== 8'hFF)
      $display("FAIL lock_pulse: got %h/l%b want ff/l1", r1, l1); else n_pass++;
    tick();
    n_checks++; if (l1 !== 1'b0 || r1 !== 8'hFE)
      $display("FAIL lock_after: got %h/l%b want fe/l0", r1, l1); else n_pass++;
  endtask

  task automatic test_taps_timing();
    do_reset();
    en = 1'b1; ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    n_checks++; if (r1 !== 8'hF0) $display("FAIL taps_pre: got %h want f0", r1); else n_pass++;
    taps_we = 1'b1; taps = 8'h00;
    tick();
    taps_we = 1'b0;
    n_checks++; if (r1 !== 8'hE1) $display("FAIL taps_old_used: got %h want e1", r1); else n_pass++;
    tick();
    n_checks++; if (r1 !== 8'hC2) $display("FAIL taps_new_used: got %h want c2", r1); else n_pass++;
  endtask

  task automatic test_async_reset_and_freeze();
    bit frozen_ok = 1;
    do_reset();
    en = 1'b1; ready = 1'b1;
    tick();
    n_checks++; if (r3 !== 8'hFE || v3 !== 1'b0)
      $display("FAIL ar_fill: got %h/v%b want fe/v0", r3, v3); else n_pass++;
    rst = 1'b1; en = 1'b0;
    #1;
    n_checks++; if (r3 !== 8'hFF || v3 !== 1'b0)
      $display("FAIL ar_immediate: got %h/v%b want ff/v0", r3, v3); else n_pass++;
    #1;
    rst = 1'b0;
    en = 1'b1;
    tick();
    en = 1'b0;
    n_checks++; if (r1 !== 8'hFE || r3 !== 8'hFE || v3 !== 1'b0)
      $display("FAIL fr_pre: got %h/%h v3=%b want fe/fe v0", r1, r3, v3); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (r1 !== 8'hFE || v1 !== 1'b0 || r3 !== 8'hFE || v3 !== 1'b0) frozen_ok = 0;
    end
    n_checks++; if (!frozen_ok)
      $display("FAIL freeze: got %h/v%b %h/v%b want fe/v0 fe/v0", r1, v1, r3, v3); else n_pass++;
    en = 1'b1;
    #1;
    n_checks++; if (v1 !== 1'b1 || v3 !== 1'b0)
      $display("FAIL unfreeze_valid: got v1=%b v3=%b want 1/0", v1, v3); else n_pass++;
    tick();
    tick();
    n_checks++; if (r1 !== 8'hF8 || r3 !== 8'hF8 || v3 !== 1'b1)
      $display("FAIL unfreeze_resume: got %h/%h v3=%b want f8/f8 v1", r1, r3, v3); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_default_sequence();
    test_period();
    test_decimation();
    test_seed();
    test_lockup();
    test_taps_timing();
    test_async_reset_and_freeze();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
